// File: rtl/quad_gen.sv
// quad_gen: quadrature encoder emulator.
// Turns step commands (direction + detent count) into a two-phase Gray-coded
// a/b waveform. Each detent is four a/b transitions, one every CLKS_PER_EDGE
// clocks.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   step_valid  in   command request
//   step_dir    in   1 = clockwise, 0 = counter-clockwise
//   step_count  in   number of detents (0 = complete immediately)
//   step_ready  out  command can be accepted (IDLE)
//   abort       in   stop the running command, outputs hold
//   a, b        out  quadrature outputs (direct flop outputs)
//   busy        out  command running
//   done        out  one-cycle pulse on normal completion
//
// state | meaning
// IDLE  | waiting for a command, phase held
// RUN   | emitting edges; one extra cycle after the final edge while done pulses
module quad_gen #(
  parameter int CLKS_PER_EDGE = 5000,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_valid,
  input  logic             step_dir,
  input  logic [CNT_W-1:0] step_count,
  output logic             step_ready,
  input  logic             abort,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done
);

  localparam int DIV_W = $clog2(CLKS_PER_EDGE);
  localparam int EDG_W = CNT_W + 2;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLKS_PER_EDGE - 1);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam logic [EDG_W-1:0] EDG_ONE    = EDG_W'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nxt;
  logic [1:0]         phase, phase_nxt;
  logic               dir_q, dir_nxt;
  logic [DIV_W-1:0]   div_q, div_nxt;
  logic [EDG_W-1:0]   edges_q, edges_nxt;
  logic               done_q, done_nxt;

  // One Gray step on {a,b}. CW: 00->10->11->01->00, CCW is the reverse.
  function automatic logic [1:0] gray_step(input logic [1:0] p, input logic cw);
    logic [1:0] n;
    if (cw) begin
      case (p)
        2'b00:   n = 2'b10;
        2'b10:   n = 2'b11;
        2'b11:   n = 2'b01;
        default: n = 2'b00;
      endcase
    end else begin
      case (p)
        2'b00:   n = 2'b01;
        2'b01:   n = 2'b11;
        2'b11:   n = 2'b10;
        default: n = 2'b00;
      endcase
    end
    return n;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= 2'b00;
      dir_q   <= 1'b0;
      div_q   <= '0;
      edges_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      dir_q   <= dir_nxt;
      div_q   <= div_nxt;
      edges_q <= edges_nxt;
      done_q  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    dir_nxt   = dir_q;
    div_nxt   = div_q;
    edges_nxt = edges_q;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (step_valid) begin
          if (step_count != '0) begin
            dir_nxt   = step_dir;
            edges_nxt = {step_count, 2'b00};
            div_nxt   = DIV_RELOAD;
            state_nxt = RUN;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          // Abort beats a coincident edge; a/b freeze where they are.
          edges_nxt = '0;
          state_nxt = IDLE;
        end else if (edges_q == '0) begin
          // Final edge already out and done is pulsing; ready rises next.
          state_nxt = IDLE;
        end else if (div_q == '0) begin
          phase_nxt = gray_step(phase, dir_q);
          edges_nxt = edges_q - EDG_ONE;
          div_nxt   = DIV_RELOAD;
          done_nxt  = (edges_q == EDG_ONE);
        end else begin
          div_nxt = div_q - DIV_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign a          = phase[1];
  assign b          = phase[0];
  assign done       = done_q;
  assign step_ready = (state == IDLE);
  assign busy       = (state == RUN);

endmodule

// File: tb/tb_quad_gen.sv
// Testbench for quad_gen: directed commands, expected a/b/done events queued
// at issue time and consumed by an independent monitor.
module tb_quad_gen;
  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step_valid = 1'b0;
  logic       step_dir = 1'b0;
  logic [7:0] step_count = 8'd0;
  logic       abort = 1'b0;
  logic       step_ready, a, b, busy, done;

  quad_gen #(.CLKS_PER_EDGE(C), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (rst),
    .step_valid (step_valid),
    .step_dir   (step_dir),
    .step_count (step_count),
    .step_ready (step_ready),
    .abort      (abort),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic [1:0] ab;
    logic       dn;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [1:0] exp_ab = 2'b00;
  int         cw_cnt = 0;
  int         ccw_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [1:0] step_ph(input logic [1:0] p, input logic cw);
    logic [1:0] n;
    if (cw) n = (p == 2'b00) ? 2'b10 : (p == 2'b10) ? 2'b11 : (p == 2'b11) ? 2'b01 : 2'b00;
    else    n = (p == 2'b00) ? 2'b01 : (p == 2'b01) ? 2'b11 : (p == 2'b11) ? 2'b10 : 2'b00;
    return n;
  endfunction

  // Queue the expected edges of a command accepted at edge t0; max_edges
  // truncates the list for commands that will be aborted or reset.
  task automatic push_cmd(input logic d, input int cnt, input int t0, input int max_edges);
    exp_t e;
    if (cnt == 0) begin
      e.t = t0; e.ab = exp_ab; e.dn = 1'b1;
      sb.push_back(e);
    end else begin
      for (int k = 1; k <= 4 * cnt && k <= max_edges; k++) begin
        exp_ab = step_ph(exp_ab, d);
        e.t = t0 + k * C; e.ab = exp_ab; e.dn = (k == 4 * cnt);
        sb.push_back(e);
      end
    end
  endtask

  task automatic issue(input logic d, input int cnt, input int max_edges, output int t0);
    @(negedge clk);
    step_valid = 1'b1;
    step_dir   = d;
    step_count = 8'(cnt);
    for (int i = 0; i < 200 && !step_ready; i++) @(negedge clk);
    check("accept_ready", step_ready, 1);
    t0 = cyc + 1;
    push_cmd(d, cnt, t0, max_edges);
    @(posedge clk);
    #1 step_valid = 1'b0;
  endtask

  task automatic wait_neg(input int target);
    for (int i = 0; i < 10000 && cyc < target; i++) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    check("drain_pending", sb.size(), 0);
  endtask

  // Monitor: any a/b change or done pulse must match the queue head.
  logic [1:0] prev_ab = 2'b00;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ab = {a, b};
    end else if ({a, b} !== prev_ab || done !== 1'b0) begin
      check("one_bit_change", ($countones({a, b} ^ prev_ab) <= 1), 1);
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_event: cycle %0d ab=%b done=%b, required no event", cyc, {a, b}, done);
      end else begin
        e = sb.pop_front();
        check("event_cycle", cyc, e.t);
        check("event_ab", {a, b}, e.ab);
        check("event_done", done, e.dn);
      end
      prev_ab = {a, b};
    end
  end

  // Loopback decoder model: one pulse per four same-direction transitions.
  logic [1:0] dprev = 2'b00;
  int         sub = 0;
  always @(negedge clk) begin
    if (rst) begin
      dprev = {a, b};
      sub   = 0;
    end else if ({a, b} != dprev) begin
      if (step_ph(dprev, 1'b1) == {a, b}) begin
        sub++;
        if (sub == 4) begin cw_cnt++; sub = 0; end
      end else if (step_ph(dprev, 1'b0) == {a, b}) begin
        sub--;
        if (sub == -4) begin ccw_cnt++; sub = 0; end
      end
      dprev = {a, b};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t0a, t0b;

    #1;
    check("rst_ab", {a, b}, 0);
    check("rst_ready", step_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // CW, one detent: 10,11,01,00 at +4,+8,+12,+16; ready back at +17.
    issue(1'b1, 1, 99, t0);
    wait_neg(t0 + 16);
    check("cw1_ready_at_done", step_ready, 0);
    @(negedge clk);
    check("cw1_ready_after", step_ready, 1);
    check("cw1_busy_after", busy, 0);
    drain();

    // CCW, three detents, loopback decode.
    cw_cnt = 0;
    ccw_cnt = 0;
    issue(1'b0, 3, 99, t0);
    drain();
    wait_neg(t0 + 50);
    check("ccw3_decoded_ccw", ccw_cnt, 3);
    check("ccw3_decoded_cw", cw_cnt, 0);

    // Zero count: done only, no edges, never busy.
    issue(1'b1, 0, 99, t0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("zero_busy", busy, 0);
      check("zero_ready", step_ready, 1);
    end
    drain();

    // Asynchronous reset while running with {a,b}=11.
    issue(1'b1, 2, 2, t0);
    wait_neg(t0 + 9);
    check("pre_reset_ab", {a, b}, 2'b11);
    #1 rst = 1'b1;
    #1;
    check("mid_reset_ab", {a, b}, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_ready", step_ready, 1);
    check("mid_reset_done", done, 0);
    sb.delete();
    exp_ab = 2'b00;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_reset_busy", busy, 0);

    // Back-to-back with step_valid held: CW 1 then CCW 1.
    @(negedge clk);
    step_valid = 1'b1;
    step_dir   = 1'b1;
    step_count = 8'd1;
    for (int i = 0; i < 200 && !step_ready; i++) @(negedge clk);
    t0a = cyc + 1;
    push_cmd(1'b1, 1, t0a, 99);
    @(negedge clk);
    step_dir   = 1'b0;
    step_count = 8'd1;
    @(negedge clk) step_valid = 1'b0;
    @(negedge clk) step_valid = 1'b1;
    for (int i = 0; i < 200 && !step_ready; i++) @(negedge clk);
    t0b = cyc + 1;
    check("b2b_accept_cycle", t0b, t0a + 18);
    push_cmd(1'b0, 1, t0b, 99);
    @(posedge clk);
    #1 step_valid = 1'b0;
    drain();
    @(negedge clk);
    check("b2b_final_ab", {a, b}, 0);

    // Abort coincident with the third edge of a CW 2 command.
    issue(1'b1, 2, 2, t0);
    wait_neg(t0 + 11);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    @(negedge clk);
    check("abort_ready", step_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_ab", {a, b}, 2'b11);
    repeat (10) @(negedge clk);
    check("abort_hold_ab", {a, b}, 2'b11);
    drain();

    // Resume from 11: 01,00,10,11.
    issue(1'b1, 1, 99, t0);
    drain();
    @(negedge clk);
    check("resume_final_ab", {a, b}, 2'b11);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
